// File: rtl/arit_defs.sv
// Shared definitions for the arithmetic unit: sequencer state encoding,
// default operand width and the saturation limits.
package arit_defs;

   localparam int N_DEF = 25;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CARGA   = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   function automatic logic signed [63:0] sat_max(input int n);
      return (64'sd1 <<< (n - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int n);
      return -(64'sd1 <<< (n - 1));
   endfunction

endpackage

// File: rtl/suma.sv
// Saturating two's-complement adder shared by the arithmetic unit.
// Clamps to the most positive/negative value when the wrapped sum flips sign.
module Suma
   import arit_defs::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s
);

   localparam logic [N-1:0] SMAX = N'(sat_max(N));
   localparam logic [N-1:0] SMIN = N'(sat_min(N));

   logic [N-1:0] raw;

   always_comb begin
      raw = a + b;
      s   = raw;
      if ((a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]))
         s = a[N-1] ? SMIN : SMAX;
   end

endmodule

// File: rtl/arbitro_suma.sv
// Round-robin arbiter that time-shares one Suma adder between NREQ requesters.
// Each operation walks IDLE -> CARGA -> ENTREGA, so one result every 3 cycles.
module arbitro_suma
   import arit_defs::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = 3,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] op_a,
   input  logic [NREQ*N-1:0] op_b,
   output logic [NREQ-1:0]   ack,
   output logic [N-1:0]      resultado,
   output logic              valido,
   output logic              sat,
   output logic [IDW-1:0]    grant_id,
   output logic              ocupado
);

   estado_t        state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [N-1:0]   ra_q, ra_d;
   logic [N-1:0]   rb_q, rb_d;
   logic [N-1:0]   res_q, res_d;
   logic           sat_q, sat_d;

   logic [N-1:0]   suma_s;
   logic [N-1:0]   raw;
   logic           ovf;
   logic [IDW-1:0] win;
   logic           unused_raw_lo;

   // First set bit at or after ptr+1, wrapping; ptr itself has lowest priority.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
      logic [IDW-1:0] w;
      logic           found;
      int             idx;
      w     = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!found && r[idx]) begin
            found = 1'b1;
            w     = IDW'(idx);
         end
      end
      return w;
   endfunction

   Suma #(.N(N)) u_suma (
      .a (ra_q),
      .b (rb_q),
      .s (suma_s)
   );

   assign raw           = ra_q + rb_q;
   assign ovf           = (ra_q[N-1] == rb_q[N-1]) && (raw[N-1] != ra_q[N-1]);
   assign unused_raw_lo = ^raw[N-2:0];
   assign win           = rr_pick(req, ptr_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      res_d   = res_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = win;
               for (int i = 0; i < NREQ; i++) begin
                  if (IDW'(i) == win) begin
                     ra_d = op_a[i*N +: N];
                     rb_d = op_b[i*N +: N];
                  end
               end
               state_d = CARGA;
            end
         end
         CARGA: begin
            res_d   = suma_s;
            sat_d   = ovf;
            state_d = ENTREGA;
         end
         ENTREGA: begin
            ptr_d   = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NREQ - 1);
         grant_q <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         res_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         res_q   <= res_d;
         sat_q   <= sat_d;
      end
   end

   // Handshake outputs decode straight from state so reset clears them at once.
   assign valido    = (state_q == ENTREGA);
   assign ack       = valido ? (NREQ'(1) << grant_q) : '0;
   assign ocupado   = (state_q != IDLE);
   assign resultado = res_q;
   assign sat       = sat_q;
   assign grant_id  = grant_q;

endmodule

// File: tb/tb_arbitro_suma.sv
// Bench for arbitro_suma: directed and random operations against a
// round-robin / saturating-sum reference model.
module tb_arbitro_suma;

   localparam int N    = 25;
   localparam int NREQ = 3;
   localparam int IDW  = 2;
   localparam longint VMAX = (64'sd1 <<< (N - 1)) - 1;
   localparam longint VMIN = -(64'sd1 <<< (N - 1));

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] op_a;
   logic [NREQ*N-1:0] op_b;
   logic [NREQ-1:0]   ack;
   logic [N-1:0]      resultado;
   logic              valido;
   logic              sat;
   logic [IDW-1:0]    grant_id;
   logic              ocupado;

   logic [N-1:0] a_v [NREQ];
   logic [N-1:0] b_v [NREQ];
   int           m_ptr;
   int           n_assert = 0;
   int           n_fail   = 0;

   arbitro_suma #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .ack       (ack),
      .resultado (resultado),
      .valido    (valido),
      .sat       (sat),
      .grant_id  (grant_id),
      .ocupado   (ocupado)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Winner = requester closest after the last served one, counting circularly.
   function automatic int ref_winner(input logic [NREQ-1:0] r, input int p);
      int best, bestd, d;
      best  = -1;
      bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         d = (i - p - 1 + 2 * NREQ) % NREQ;
         if (r[i] && d < bestd) begin
            bestd = d;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic ref_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] s, output logic st);
      longint sa, sb, t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t  = sa + sb;
      st = 1'b0;
      if (t > VMAX) begin t = VMAX; st = 1'b1; end
      if (t < VMIN) begin t = VMIN; st = 1'b1; end
      s = t[N-1:0];
   endtask

   task automatic pack_ops();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i*N +: N] = a_v[i];
         op_b[i*N +: N] = b_v[i];
      end
   endtask

   // Starts at a negedge with the DUT in IDLE, ends at a negedge back in IDLE.
   task automatic serve(input logic [NREQ-1:0] r, input bit mess, input logic [NREQ-1:0] r_after);
      int              w, cyc;
      bit              done;
      logic [N-1:0]    e_s;
      logic            e_sat;
      logic [NREQ-1:0] e_ack;
      req = r;
      pack_ops();
      w = ref_winner(r, m_ptr);
      ref_sum(a_v[w], b_v[w], e_s, e_sat);
      e_ack    = '0;
      e_ack[w] = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 8) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (mess && cyc == 1) op_a[w*N +: N] = ~a_v[w];
         if (valido === 1'b1) done = 1'b1;
         else chk("ack_early", 64'(ack), 64'(0));
      end
      chk("valido_seen", 64'(done), 64'(1));
      chk("latency", 64'(cyc), 64'(2));
      chk("ack", 64'(ack), 64'(e_ack));
      chk("grant_id", 64'(grant_id), 64'(w));
      chk("resultado", 64'(resultado), 64'(e_s));
      chk("sat", 64'(sat), 64'(e_sat));
      m_ptr = w;
      req   = r_after;
      @(posedge clk);
      @(negedge clk);
      chk("idle_ocupado", 64'(ocupado), 64'(0));
      chk("idle_ack", 64'(ack), 64'(0));
      chk("idle_valido", 64'(valido), 64'(0));
      chk("hold_resultado", 64'(resultado), 64'(e_s));
      chk("hold_sat", 64'(sat), 64'(e_sat));
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
      pack_ops();
      m_ptr = NREQ - 1;
      #1;
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_valido", 64'(valido), 64'(0));
      chk("rst_resultado", 64'(resultado), 64'(0));
      chk("rst_sat", 64'(sat), 64'(0));
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_ocupado", 64'(ocupado), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fairness: all requesting gives 0,1,2,0; then 101 after serving 0 gives 2.
      for (int i = 0; i < NREQ; i++) begin a_v[i] = N'(10 * i + 1); b_v[i] = N'(i); end
      for (int k = 0; k < 4; k++) serve(3'b111, 1'b0, 3'b111);
      serve(3'b101, 1'b0, 3'b000);

      a_v[0] = N'(5); b_v[0] = N'(7);
      serve(3'b001, 1'b0, 3'b000);
      a_v[1] = N'(16777215); b_v[1] = N'(1);
      serve(3'b010, 1'b0, 3'b000);
      a_v[2] = N'(-16777216); b_v[2] = N'(-1);
      serve(3'b100, 1'b0, 3'b000);
      a_v[2] = N'(-5); b_v[2] = N'(3);
      serve(3'b100, 1'b0, 3'b000);

      // Operand change during CARGA must not leak into the result.
      a_v[0] = N'(1000); b_v[0] = N'(-3);
      serve(3'b001, 1'b1, 3'b000);
      // New request raised during ENTREGA waits for the next IDLE.
      a_v[1] = N'(42); b_v[1] = N'(-50);
      serve(3'b010, 1'b0, 3'b100);
      serve(3'b100, 1'b0, 3'b000);

      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 3))
               0:       a_v[i] = N'(VMAX - longint'($urandom_range(0, 20)));
               1:       a_v[i] = N'(VMIN + longint'($urandom_range(0, 20)));
               default: a_v[i] = N'($urandom);
            endcase
            case ($urandom_range(0, 3))
               0:       b_v[i] = N'(VMAX - longint'($urandom_range(0, 20)));
               1:       b_v[i] = N'(VMIN + longint'($urandom_range(0, 20)));
               default: b_v[i] = N'($urandom);
            endcase
         end
         serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), bit'($urandom_range(0, 1)), 3'b000);
      end

      // Reset during CARGA aborts the operation with no ack.
      a_v[0] = N'(77); b_v[0] = N'(1);
      req = 3'b001;
      pack_ops();
      @(posedge clk);
      @(negedge clk);
      chk("carga_ocupado", 64'(ocupado), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_ack", 64'(ack), 64'(0));
      chk("abort_valido", 64'(valido), 64'(0));
      chk("abort_resultado", 64'(resultado), 64'(0));
      chk("abort_sat", 64'(sat), 64'(0));
      chk("abort_grant", 64'(grant_id), 64'(0));
      chk("abort_ocupado", 64'(ocupado), 64'(0));
      req = '0;
      @(negedge clk);
      chk("abort_ack_hold", 64'(ack), 64'(0));
      rst_n = 1'b1;
      m_ptr = NREQ - 1;
      @(negedge clk);
      a_v[1] = N'(123); b_v[1] = N'(456);
      serve(3'b010, 1'b0, 3'b000);
      serve(3'b111, 1'b0, 3'b000);

      // Second reset: priority restarts at requester 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = NREQ - 1;
      @(negedge clk);
      serve(3'b111, 1'b0, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
